// File: rtl/pci_sim_pkg.sv
// Shared definitions for the PCI simulation-side initiator models:
// bus command codes, initiator state encoding and default retry budget.
package pci_sim_pkg;

    localparam logic [3:0] CMD_MEM_READ  = 4'h6;
    localparam logic [3:0] CMD_MEM_WRITE = 4'h7;

    localparam int DEFAULT_RETRY_MAX = 7;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        ADDR,
        DATA,
        CHECK
    } init_state_t;

endpackage

// File: rtl/mem_init_buf.sv
// Word buffer for the memory initiator: one synchronous write port and two
// combinational read ports (testbench readback and write-data source).
module mem_init_buf #(
    parameter int LEN_W = 4
) (
    input  logic             CLK,
    input  logic             we,
    input  logic [LEN_W-1:0] waddr,
    input  logic [31:0]      wdata,
    input  logic [LEN_W-1:0] raddr_a,
    output logic [31:0]      rdata_a,
    input  logic [LEN_W-1:0] raddr_b,
    output logic [31:0]      rdata_b
);

    logic [31:0] mem [2**LEN_W];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/mem_initiator.sv
// Initiator user application for the PCI core master interface: streams a
// buffered memory write/read burst and re-requests after core disconnects.
module mem_initiator
    import pci_sim_pkg::*;
#(
    parameter int LEN_W     = 4,
    parameter int RETRY_MAX = DEFAULT_RETRY_MAX
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             cmd_start,
    input  logic             cmd_wr,
    input  logic [31:0]      cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             buf_we,
    input  logic [LEN_W-1:0] buf_addr,
    input  logic [31:0]      buf_wdata,
    output logic [31:0]      buf_rdata,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             request,
    output logic             m_wrdn,
    output logic [3:0]       m_cbe,
    output logic             m_ready,
    output logic             complete,
    output logic [31:0]      adio_in,
    input  logic [31:0]      adio_out,
    input  logic             m_addr_n,
    input  logic             m_data,
    input  logic             m_data_vld,
    input  logic             time_out
);

    localparam int RW = $clog2(RETRY_MAX + 2);
    localparam logic [LEN_W:0] CNT_ONE  = (LEN_W + 1)'(1);
    localparam logic [LEN_W:0] CNT_TWO  = (LEN_W + 1)'(2);
    localparam logic [LEN_W:0] CNT_FULL = (LEN_W + 1)'(2 ** LEN_W);
    localparam logic [RW-1:0]  RETRY_LIMIT = RW'(RETRY_MAX);

    init_state_t state, next_state;

    logic             wr_q;
    logic [29:0]      addr_q;
    logic [LEN_W:0]   cnt_q;
    logic [LEN_W-1:0] idx_q;
    logic [RW-1:0]    retries_q;
    logic             m_data_q;
    logic             done_q;
    logic             err_q;

    logic             start;
    logic             xfer;
    logic             data_end;
    logic             drive_en;
    logic [31:0]      drive_val;
    logic [31:0]      buf_word;
    logic             buf_wr_en;
    logic [LEN_W-1:0] buf_waddr;
    logic [31:0]      buf_wdata_mux;
    logic             addr_lsb_unused;

    assign addr_lsb_unused = ^cmd_addr[1:0];

    // A timed-out cycle transfers nothing, even if the core flagged a word.
    assign start    = (state == IDLE) && cmd_start;
    assign xfer     = (state == DATA) && m_data_vld && !time_out;
    assign data_end = m_data_q && !m_data;
    assign busy     = (state != IDLE);

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (cmd_start) next_state = REQ;
            REQ:     next_state = ADDR;
            ADDR: begin
                if (time_out)       next_state = IDLE;
                else if (!m_addr_n) next_state = DATA;
            end
            DATA: begin
                if (time_out)      next_state = IDLE;
                else if (data_end) next_state = CHECK;
            end
            CHECK: begin
                if (cnt_q == '0 || retries_q == RETRY_LIMIT) next_state = IDLE;
                else                                         next_state = REQ;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        request   = 1'b0;
        m_wrdn    = 1'b0;
        m_cbe     = 4'h0;
        m_ready   = 1'b0;
        complete  = 1'b0;
        drive_en  = 1'b0;
        drive_val = '0;
        case (state)
            REQ: begin
                request = 1'b1;
                m_wrdn  = wr_q;
                m_cbe   = wr_q ? CMD_MEM_WRITE : CMD_MEM_READ;
            end
            ADDR: begin
                m_wrdn    = wr_q;
                m_cbe     = wr_q ? CMD_MEM_WRITE : CMD_MEM_READ;
                drive_en  = 1'b1;
                drive_val = {addr_q, 2'b00};
            end
            DATA: begin
                m_wrdn    = wr_q;
                m_ready   = 1'b1;
                complete  = (cnt_q == CNT_ONE) || ((cnt_q == CNT_TWO) && m_data_vld);
                drive_en  = wr_q;
                drive_val = buf_word;
            end
            CHECK: begin
                m_wrdn = wr_q;
            end
            default: ;
        endcase
    end

    assign adio_in = drive_en ? drive_val : 'z;

    // Burst bookkeeping; address and count persist across disconnects so a
    // re-request resumes exactly where the core stopped.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            wr_q      <= 1'b0;
            addr_q    <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            retries_q <= '0;
            m_data_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            m_data_q <= m_data;
            done_q   <= (state == CHECK) && (cnt_q == '0);
            err_q    <= ((state == CHECK) && (cnt_q != '0) && (retries_q == RETRY_LIMIT))
                     || (((state == ADDR) || (state == DATA)) && time_out);
            if (start) begin
                wr_q      <= cmd_wr;
                addr_q    <= cmd_addr[31:2];
                cnt_q     <= (cmd_len == '0) ? CNT_FULL : {1'b0, cmd_len};
                idx_q     <= '0;
                retries_q <= '0;
            end else if (xfer) begin
                idx_q  <= idx_q + 1'b1;
                cnt_q  <= cnt_q - CNT_ONE;
                addr_q <= addr_q + 30'd1;
            end else if ((state == CHECK) && (next_state == REQ)) begin
                retries_q <= retries_q + 1'b1;
            end
        end
    end

    assign done = done_q;
    assign err  = err_q;

    assign buf_wr_en     = (buf_we && !busy) || (xfer && !wr_q);
    assign buf_waddr     = busy ? idx_q : buf_addr;
    assign buf_wdata_mux = busy ? adio_out : buf_wdata;

    mem_init_buf #(
        .LEN_W (LEN_W)
    ) u_buf (
        .CLK     (CLK),
        .we      (buf_wr_en),
        .waddr   (buf_waddr),
        .wdata   (buf_wdata_mux),
        .raddr_a (buf_addr),
        .rdata_a (buf_rdata),
        .raddr_b (idx_q),
        .rdata_b (buf_word)
    );

endmodule

// File: tb/tb_mem_initiator.sv
// Directed self-checking bench for mem_initiator: write/read bursts,
// disconnect resume, retry exhaustion, timeout and mid-burst reset.
module tb_mem_initiator;

    logic        CLK;
    logic        reset;
    logic        cmd_start;
    logic        cmd_wr;
    logic [31:0] cmd_addr;
    logic [3:0]  cmd_len;
    logic        buf_we;
    logic [3:0]  buf_addr;
    logic [31:0] buf_wdata;
    logic [31:0] buf_rdata;
    logic        busy;
    logic        done;
    logic        err;
    logic        request;
    logic        m_wrdn;
    logic [3:0]  m_cbe;
    logic        m_ready;
    logic        complete;
    wire  [31:0] adio_in;
    logic [31:0] adio_out;
    logic        m_addr_n;
    logic        m_data;
    logic        m_data_vld;
    logic        time_out;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    int err_seen = 0;
    int req_seen = 0;

    mem_initiator #(.LEN_W(4), .RETRY_MAX(7)) dut (
        .CLK        (CLK),
        .reset      (reset),
        .cmd_start  (cmd_start),
        .cmd_wr     (cmd_wr),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .buf_we     (buf_we),
        .buf_addr   (buf_addr),
        .buf_wdata  (buf_wdata),
        .buf_rdata  (buf_rdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .request    (request),
        .m_wrdn     (m_wrdn),
        .m_cbe      (m_cbe),
        .m_ready    (m_ready),
        .complete   (complete),
        .adio_in    (adio_in),
        .adio_out   (adio_out),
        .m_addr_n   (m_addr_n),
        .m_data     (m_data),
        .m_data_vld (m_data_vld),
        .time_out   (time_out)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Pulse counters sampled mid-cycle.
    always @(negedge CLK) begin
        if (done)    done_seen++;
        if (err)     err_seen++;
        if (request) req_seen++;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic load_word(input int i, input logic [31:0] d);
        buf_we    = 1'b1;
        buf_addr  = 4'(i);
        buf_wdata = d;
        tick();
        buf_we = 1'b0;
    endtask

    task automatic issue(input logic wr, input logic [31:0] a, input logic [3:0] len);
        cmd_wr    = wr;
        cmd_addr  = a;
        cmd_len   = len;
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %0b want 0", busy); end
        checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("[TB] FAIL reset_done_err got %0b%0b want 00", done, err); end
        checks++; if (request !== 1'b0 || m_wrdn !== 1'b0 || m_ready !== 1'b0 || complete !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_ctrl got req=%0b wrdn=%0b rdy=%0b cmpl=%0b want 0000", request, m_wrdn, m_ready, complete);
        end
        checks++; if (m_cbe !== 4'h0) begin errors++; $display("[TB] FAIL reset_cbe got %h want 0", m_cbe); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_write_burst();
        logic [31:0] words [4];
        int d0;
        words[0] = 32'h11111111; words[1] = 32'h22222222;
        words[2] = 32'h33333333; words[3] = 32'h44444444;
        for (int i = 0; i < 4; i++) load_word(i, words[i]);
        d0 = done_seen;
        issue(1'b1, 32'h4000_0003, 4'd4);
        checks++; if (request !== 1'b1 || m_wrdn !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("[TB] FAIL wr_req got req=%0b wrdn=%0b busy=%0b want 111", request, m_wrdn, busy);
        end
        checks++; if (m_cbe !== 4'h7) begin errors++; $display("[TB] FAIL wr_cbe got %h want 7", m_cbe); end
        tick();
        checks++; if (adio_in !== 32'h4000_0000 || request !== 1'b0) begin
            errors++; $display("[TB] FAIL wr_addr got %h req=%0b want 40000000 req=0", adio_in, request);
        end
        m_addr_n = 1'b0;
        tick();
        m_addr_n = 1'b1; m_data = 1'b1; m_data_vld = 1'b1;
        for (int w = 0; w < 4; w++) begin
            #1;
            checks++; if (adio_in !== words[w]) begin errors++; $display("[TB] FAIL wr_word%0d got %h want %h", w, adio_in, words[w]); end
            checks++; if (complete !== (w >= 2) || m_ready !== 1'b1 || m_cbe !== 4'h0) begin
                errors++; $display("[TB] FAIL wr_phase%0d got cmpl=%0b rdy=%0b cbe=%h want cmpl=%0b rdy=1 cbe=0", w, complete, m_ready, m_cbe, (w >= 2));
            end
            tick();
        end
        m_data = 1'b0; m_data_vld = 1'b0;
        tick();
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("[TB] FAIL wr_check got busy=%0b done=%0b want 10", busy, done); end
        tick();
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL wr_done got done=%0b busy=%0b want 10", done, busy); end
        tick();
        checks++; if (done_seen - d0 !== 1 || done !== 1'b0) begin errors++; $display("[TB] FAIL wr_done_once got %0d pulses want 1", done_seen - d0); end
    endtask

    task automatic test_read_single();
        issue(1'b0, 32'h0000_2000, 4'd1);
        checks++; if (m_cbe !== 4'h6 || m_wrdn !== 1'b0) begin errors++; $display("[TB] FAIL rd_cmd got cbe=%h wrdn=%0b want 6 0", m_cbe, m_wrdn); end
        tick();
        m_addr_n = 1'b0;
        tick();
        m_addr_n = 1'b1; m_data = 1'b1;
        #1;
        checks++; if (complete !== 1'b1 || m_ready !== 1'b1) begin errors++; $display("[TB] FAIL rd_complete got cmpl=%0b rdy=%0b want 11", complete, m_ready); end
        m_data_vld = 1'b1; adio_out = 32'h0123_4567;
        tick();
        m_data = 1'b0; m_data_vld = 1'b0; adio_out = 32'h0;
        tick();
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL rd_done got %0b want 1", done); end
        buf_addr = 4'd0;
        #1;
        checks++; if (buf_rdata !== 32'h0123_4567) begin errors++; $display("[TB] FAIL rd_capture got %h want 01234567", buf_rdata); end
        tick();
    endtask

    task automatic test_disconnect_resume();
        int d0;
        int r0;
        for (int i = 0; i < 16; i++) load_word(i, 32'hA500_0000 + 32'(i));
        d0 = done_seen;
        r0 = req_seen;
        issue(1'b1, 32'h0000_1000, 4'd0);
        tick();
        checks++; if (adio_in !== 32'h0000_1000) begin errors++; $display("[TB] FAIL dc_addr1 got %h want 00001000", adio_in); end
        m_addr_n = 1'b0;
        tick();
        m_addr_n = 1'b1; m_data = 1'b1; m_data_vld = 1'b1;
        for (int w = 0; w < 5; w++) begin
            #1;
            checks++; if (adio_in !== 32'hA500_0000 + 32'(w)) begin errors++; $display("[TB] FAIL dc_word%0d got %h want %h", w, adio_in, 32'hA500_0000 + 32'(w)); end
            tick();
        end
        m_data = 1'b0; m_data_vld = 1'b0;
        tick();
        tick();
        checks++; if (request !== 1'b1 || done !== 1'b0) begin errors++; $display("[TB] FAIL dc_rereq got req=%0b done=%0b want 10", request, done); end
        tick();
        checks++; if (adio_in !== 32'h0000_1014) begin errors++; $display("[TB] FAIL dc_addr2 got %h want 00001014", adio_in); end
        m_addr_n = 1'b0;
        tick();
        m_addr_n = 1'b1; m_data = 1'b1; m_data_vld = 1'b1;
        for (int w = 5; w < 16; w++) begin
            #1;
            checks++; if (adio_in !== 32'hA500_0000 + 32'(w)) begin errors++; $display("[TB] FAIL dc_word%0d got %h want %h", w, adio_in, 32'hA500_0000 + 32'(w)); end
            checks++; if (complete !== (w >= 14)) begin errors++; $display("[TB] FAIL dc_cmpl%0d got %0b want %0b", w, complete, (w >= 14)); end
            tick();
        end
        m_data = 1'b0; m_data_vld = 1'b0;
        tick();
        tick();
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL dc_done got done=%0b busy=%0b want 10", done, busy); end
        tick();
        checks++; if (req_seen - r0 !== 2 || done_seen - d0 !== 1) begin
            errors++; $display("[TB] FAIL dc_counts got req=%0d done=%0d want 2 1", req_seen - r0, done_seen - d0);
        end
    endtask

    task automatic test_retry_limit();
        int d0;
        int e0;
        int r0;
        d0 = done_seen; e0 = err_seen; r0 = req_seen;
        issue(1'b0, 32'h0000_3000, 4'd4);
        for (int it = 0; it < 8; it++) begin
            checks++; if (request !== 1'b1) begin errors++; $display("[TB] FAIL rt_req%0d got %0b want 1", it, request); end
            tick();
            m_addr_n = 1'b0;
            tick();
            m_addr_n = 1'b1; m_data = 1'b1;
            tick();
            m_data = 1'b0;
            tick();
            tick();
        end
        checks++; if (err !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("[TB] FAIL rt_err got err=%0b busy=%0b done=%0b want 100", err, busy, done);
        end
        tick();
        checks++; if (req_seen - r0 !== 8 || err_seen - e0 !== 1 || done_seen - d0 !== 0) begin
            errors++; $display("[TB] FAIL rt_counts got req=%0d err=%0d done=%0d want 8 1 0", req_seen - r0, err_seen - e0, done_seen - d0);
        end
    endtask

    task automatic test_timeout_addr();
        load_word(0, 32'hCAFE_F00D);
        issue(1'b0, 32'h0000_5000, 4'd2);
        tick();
        time_out = 1'b1; m_data_vld = 1'b1; adio_out = 32'hBAD0_BAD0;
        tick();
        time_out = 1'b0; m_data_vld = 1'b0; adio_out = 32'h0;
        checks++; if (err !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL to_err got err=%0b busy=%0b want 10", err, busy); end
        buf_addr = 4'd0;
        #1;
        checks++; if (buf_rdata !== 32'hCAFE_F00D) begin errors++; $display("[TB] FAIL to_nocapture got %h want cafef00d", buf_rdata); end
        tick();
        checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL to_pulse got %0b want 0", err); end
    endtask

    task automatic test_reset_mid_burst();
        int d0;
        int e0;
        d0 = done_seen; e0 = err_seen;
        issue(1'b1, 32'h0000_6000, 4'd4);
        tick();
        m_addr_n = 1'b0;
        tick();
        m_addr_n = 1'b1; m_data = 1'b1; m_data_vld = 1'b1;
        #1;
        checks++; if (m_ready !== 1'b1) begin errors++; $display("[TB] FAIL rs_data got rdy=%0b want 1", m_ready); end
        #2 reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || request !== 1'b0 || m_ready !== 1'b0 || complete !== 1'b0 || m_wrdn !== 1'b0 || m_cbe !== 4'h0) begin
            errors++; $display("[TB] FAIL rs_outputs got busy=%0b req=%0b rdy=%0b cmpl=%0b wrdn=%0b cbe=%h want all 0", busy, request, m_ready, complete, m_wrdn, m_cbe);
        end
        m_data = 1'b0; m_data_vld = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        checks++; if (done_seen - d0 !== 0 || err_seen - e0 !== 0) begin
            errors++; $display("[TB] FAIL rs_nopulse got done=%0d err=%0d want 0 0", done_seen - d0, err_seen - e0);
        end
        issue(1'b0, 32'h0000_7000, 4'd1);
        checks++; if (request !== 1'b1) begin errors++; $display("[TB] FAIL rs_rereq got %0b want 1", request); end
        tick();
        m_addr_n = 1'b0;
        tick();
        m_addr_n = 1'b1; m_data = 1'b1; m_data_vld = 1'b1; adio_out = 32'h89AB_CDEF;
        tick();
        m_data = 1'b0; m_data_vld = 1'b0; adio_out = 32'h0;
        tick();
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL rs_done got %0b want 1", done); end
        buf_addr = 4'd0;
        #1;
        checks++; if (buf_rdata !== 32'h89AB_CDEF) begin errors++; $display("[TB] FAIL rs_capture got %h want 89abcdef", buf_rdata); end
        tick();
    endtask

    initial begin
        reset = 1'b1;
        cmd_start = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
        buf_we = 1'b0; buf_addr = '0; buf_wdata = '0;
        adio_out = '0; m_addr_n = 1'b1; m_data = 1'b0; m_data_vld = 1'b0; time_out = 1'b0;
        test_reset();
        test_write_burst();
        test_read_single();
        test_disconnect_resume();
        test_retry_limit();
        test_timeout_addr();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
